hazard_scoreboard: RTL
======================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NSRC, default 2: number of single-cycle bypass sources; index 0 is the youngest (EM), higher indices are older (MW, ...).
REQ-002 SHALL have parameter REG_W, default 5: register index width; NREGS = 2**REG_W.
REQ-003 SHALL have parameter TIMEOUT, default 255: stall-cycle limit before the error flag is raised.
REQ-004 SHALL define local SEL_W = clog2(NSRC+2) for the select width.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  clock, all state on rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 rs1_de, rs2_de  in  REG_W each  source registers of the instruction in DE.
REQ-009 use_rs1, use_rs2  in  1 each  the DE instruction reads that source.
REQ-010 issue_valid  in  1  the DE instruction advances to EM this cycle.
REQ-011 issue_long  in  1  the issuing instruction is long-latency (load, mul/div).
REQ-012 issue_rd  in  REG_W  destination of the issuing instruction.
REQ-013 byp_valid, byp_wr  in  NSRC each  bypass source k holds a valid instruction / writes a register.
REQ-014 byp_rd  in  NSRC*REG_W  destination of bypass source k in slice k.
REQ-015 wbl_valid, wbl_rd  in  1, REG_W  long-latency completion writing wbl_rd this cycle.
REQ-016 fwd_sel1, fwd_sel2  out  SEL_W each  0 = register file, k+1 = bypass source k, NSRC+1 = long completion port.
REQ-017 stall  out  1  hold DE and earlier stages.
REQ-018 pend_cnt  out  REG_W+1  number of registers with a pending long write.
REQ-019 stall_cycles  out  16  saturating count of stalled cycles.
REQ-020 timeout_err  out  1  sticky: a single stall episode exceeded TIMEOUT cycles.

Function
REQ-021 SHALL hold a pending bit per register; the bit for x0 is always 0.
REQ-022 On a clock edge with issue_valid=1, stall=0, issue_long=1 and issue_rd!=0, SHALL set pending[issue_rd].
REQ-023 On a clock edge with wbl_valid=1, SHALL clear pending[wbl_rd].
REQ-024 If both REQ-022 and REQ-023 apply to the same register on the same edge, the set SHALL win.
REQ-025 SHALL ignore issue_valid while stall=1.
REQ-026 For each source s, fwd_sel SHALL be 0 if use_rs=0 or rs=0.
REQ-027 Otherwise, fwd_sel SHALL be k+1 for the lowest k with byp_valid[k] & byp_wr[k] & byp_rd[k]==rs.
REQ-028 If no bypass source matches, fwd_sel SHALL be NSRC+1 when wbl_valid & wbl_rd==rs.
REQ-029 Otherwise fwd_sel SHALL be 0.
REQ-030 fwd_sel SHALL be combinational with zero-cycle latency.
REQ-031 stall SHALL be asserted combinationally when, for either used non-zero source, pending[rs]=1 and the source is not satisfied by the completion port (REQ-028).
REQ-032 A bypass-source match SHALL NOT suppress a stall caused by a pending bit, because the pending write is younger.
REQ-033 pend_cnt SHALL equal the popcount of the pending bits, registered, updated on the same edge as those bits.
REQ-034 SHALL implement an FSM with states RUN and STALL, reset to RUN.
REQ-035 The FSM SHALL go RUN->STALL on an edge with stall=1, stay in STALL while stall=1, and go STALL->RUN on an edge with stall=0.
REQ-036 SHALL hold an episode counter that is cleared on entry to RUN and incremented on each edge in STALL with stall=1.
REQ-037 SHALL set timeout_err when the episode counter reaches TIMEOUT; timeout_err SHALL be cleared only by rst.
REQ-038 stall_cycles SHALL increment on each edge with stall=1 and saturate at 16'hFFFF.

Reset
REQ-039 While rst=1 at an edge, SHALL clear all pending bits, pend_cnt, stall_cycles, timeout_err and the episode counter, and set the FSM to RUN.
REQ-040 Issue and completion inputs SHALL be ignored on a reset edge.
REQ-041 After reset, stall SHALL be 0 and fwd_sel SHALL be a pure function of the bypass inputs.
REQ-042 Reset mid-stall SHALL drop stall in the next cycle.

Verification
REQ-043 With NSRC=2: rs1=5, byp0 rd=5 wr=1, byp1 rd=5 wr=1 -> fwd_sel1=1; with byp0 wr=0 -> fwd_sel1=2; with rs1=0 -> fwd_sel1=0.
REQ-044 Issue a long op with rd=7, next cycle rs2=7 used -> stall=1 and pend_cnt=1; apply wbl_valid rd=7 -> same cycle stall=0 and fwd_sel2=3; next cycle pend_cnt=0.
REQ-045 In the same cycle, wbl rd=9 completes and a long op with rd=9 issues -> pending[9] stays 1 and pend_cnt is unchanged.
REQ-046 Long op pending on rd=3, rs1=3 held for TIMEOUT+1 cycles -> timeout_err=1, which stays 1 after the completion; stall_cycles=TIMEOUT+1.
REQ-047 Issue a long op with rd=0 -> pend_cnt stays 0 and there is no stall.
REQ-048 Assert rst during a stall on rd=4 -> next cycle stall=0, pend_cnt=0, FSM in RUN.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: tracks pending long-latency writes, selects
// operand forwarding sources, and raises stall plus stall statistics.
module hazard_scoreboard #(
  parameter int unsigned NSRC    = 2,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned TIMEOUT = 255,
  localparam int unsigned SEL_W  = $clog2(NSRC + 2)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REG_W-1:0]        rs1_de,
  input  logic [REG_W-1:0]        rs2_de,
  input  logic                    use_rs1,
  input  logic                    use_rs2,
  input  logic                    issue_valid,
  input  logic                    issue_long,
  input  logic [REG_W-1:0]        issue_rd,
  input  logic [NSRC-1:0]         byp_valid,
  input  logic [NSRC-1:0]         byp_wr,
  input  logic [NSRC*REG_W-1:0]   byp_rd,
  input  logic                    wbl_valid,
  input  logic [REG_W-1:0]        wbl_rd,
  output logic [SEL_W-1:0]        fwd_sel1,
  output logic [SEL_W-1:0]        fwd_sel2,
  output logic                    stall,
  output logic [REG_W:0]          pend_cnt,
  output logic [15:0]             stall_cycles,
  output logic                    timeout_err
);

  localparam int unsigned NREGS = 2 ** REG_W;
  localparam int unsigned EP_W  = $clog2(TIMEOUT + 2);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  state_t            state;
  logic [NREGS-1:0]  pending;
  logic [NREGS-1:0]  pend_nxt;
  logic [REG_W:0]    pend_cnt_nxt;
  logic [EP_W-1:0]   ep_cnt;
  logic              hz1;
  logic              hz2;
  logic              wbl_hit1;
  logic              wbl_hit2;

  // Forwarding select: youngest matching bypass wins, then the completion port.
  always_comb begin
    fwd_sel1 = '0;
    fwd_sel2 = '0;
    if (use_rs1 && rs1_de != '0) begin
      if (wbl_valid && wbl_rd == rs1_de) fwd_sel1 = SEL_W'(NSRC + 1);
      for (int k = int'(NSRC) - 1; k >= 0; k--) begin
        if (byp_valid[k] && byp_wr[k] && byp_rd[k*REG_W +: REG_W] == rs1_de)
          fwd_sel1 = SEL_W'(k + 1);
      end
    end
    if (use_rs2 && rs2_de != '0) begin
      if (wbl_valid && wbl_rd == rs2_de) fwd_sel2 = SEL_W'(NSRC + 1);
      for (int k = int'(NSRC) - 1; k >= 0; k--) begin
        if (byp_valid[k] && byp_wr[k] && byp_rd[k*REG_W +: REG_W] == rs2_de)
          fwd_sel2 = SEL_W'(k + 1);
      end
    end
  end

  // Stall on a pending source unless the long write completes this cycle;
  // bypass matches are older than the pending write and cannot resolve it.
  always_comb begin
    wbl_hit1 = wbl_valid && (wbl_rd == rs1_de);
    wbl_hit2 = wbl_valid && (wbl_rd == rs2_de);
    hz1      = use_rs1 && (rs1_de != '0) && pending[rs1_de] && !wbl_hit1;
    hz2      = use_rs2 && (rs2_de != '0) && pending[rs2_de] && !wbl_hit2;
    stall    = hz1 || hz2;
  end

  // Next pending vector: completion clears, issue sets (set wins), x0 never pending.
  always_comb begin
    pend_nxt = pending;
    if (wbl_valid) pend_nxt[wbl_rd] = 1'b0;
    if (issue_valid && !stall && issue_long && issue_rd != '0)
      pend_nxt[issue_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
    pend_cnt_nxt = '0;
    for (int i = 0; i < int'(NREGS); i++) begin
      pend_cnt_nxt = pend_cnt_nxt + (REG_W+1)'(pend_nxt[i]);
    end
  end

  // Pending bits and their registered popcount.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      pending  <= pend_nxt;
      pend_cnt <= pend_cnt_nxt;
    end
  end

  // RUN/STALL episode tracking, total stall counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      ep_cnt       <= '0;
      stall_cycles <= '0;
      timeout_err  <= 1'b0;
    end else begin
      if (stall && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
      case (state)
        RUN: begin
          ep_cnt <= '0;
          if (stall) state <= STALL;
        end
        STALL: begin
          if (stall) begin
            if (ep_cnt != EP_W'(TIMEOUT)) ep_cnt <= ep_cnt + EP_W'(1);
            if (({1'b0, ep_cnt} + (EP_W+1)'(1)) >= (EP_W+1)'(TIMEOUT))
              timeout_err <= 1'b1;
          end else begin
            state  <= RUN;
            ep_cnt <= '0;
          end
        end
        default: begin
          state  <= RUN;
          ep_cnt <= '0;
        end
      endcase
    end
  end

endmodule
